// File: rtl/mc_control.sv
// mc_control: sequencing FSM for the multi-cycle MIPS datapath.
//
// Steps each instruction through fetch, decode, execute, memory and writeback
// states. It drives the ALU function code, datapath mux selects and write
// enables from the current state, with some outputs also depending on the
// held opcode. It also counts fetched instructions.
//
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous, active-high
//   opcode    - IR[31:26], stable from DECODE onward
//   funct     - IR[5:0]
//   zero      - ALU result == 0, used for beq/bne
//   alufun    - ALU function; bit3 inverts B and sets carry-in
//   alusrca   - 0 = PC, 1 = register A
//   alusrcb   - 00 reg B, 01 const 4, 10 extended imm, 11 sign-ext imm<<2
//   zext      - zero-extend the immediate instead of sign-extending it
//   iord      - memory address 0 = PC, 1 = ALUOut
//   memwrite, irwrite, regwrite - write enables
//   regdst    - 0 = rt, 1 = rd
//   memtoreg  - 0 = ALUOut, 1 = MDR
//   pcsrc     - 00 ALU result, 01 ALUOut, 10 jump target
//   pcen      - PC write enable
//   illegal   - one-cycle pulse in DECODE for an unsupported instruction
//   icount    - instructions fetched since reset, wraps
module mc_control #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  output logic [3:0]           alufun,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic                 zext,
  output logic                 iord,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 regwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic [1:0]           pcsrc,
  output logic                 pcen,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] icount
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC, ALUWB, BRANCH, IMMEX, IMMWB, JUMP
  } state_t;

  state_t state;
  state_t next_state;
  logic   decode_illegal;

  // R-type funct decode: ALU code for EXEC and whether the funct is supported.
  logic       funct_ok;
  logic [3:0] rtype_alufun;

  always_comb begin
    funct_ok     = 1'b1;
    rtype_alufun = 4'b0110;
    case (funct)
      6'b100000, 6'b100001: rtype_alufun = 4'b0110;
      6'b100010, 6'b100011: rtype_alufun = 4'b1110;
      6'b100100:            rtype_alufun = 4'b0000;
      6'b100101:            rtype_alufun = 4'b0001;
      6'b100110:            rtype_alufun = 4'b0010;
      6'b100111:            rtype_alufun = 4'b0011;
      6'b101010:            rtype_alufun = 4'b1111;
      default:              funct_ok     = 1'b0;
    endcase
  end

  // Immediate-class decode; logical immediates are zero-extended and the
  // extension choice must persist into IMMWB because the datapath may
  // still be using the extended value there.
  logic [3:0] imm_alufun;
  logic       imm_zext;

  always_comb begin
    imm_alufun = 4'b0110;
    imm_zext   = 1'b0;
    case (opcode)
      OP_SLTI: imm_alufun = 4'b1111;
      OP_ANDI: begin imm_alufun = 4'b0000; imm_zext = 1'b1; end
      OP_ORI:  begin imm_alufun = 4'b0001; imm_zext = 1'b1; end
      OP_XORI: begin imm_alufun = 4'b0010; imm_zext = 1'b1; end
      default: imm_alufun = 4'b0110;
    endcase
  end

  // Next-state logic. An instruction that DECODE cannot dispatch returns
  // straight to FETCH and is flagged as illegal for that one cycle.
  always_comb begin
    next_state     = FETCH;
    decode_illegal = 1'b0;
    case (state)
      FETCH:  next_state = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE: begin
            if (funct_ok) next_state = EXEC;
            else          decode_illegal = 1'b1;
          end
          OP_BEQ, OP_BNE: next_state = BRANCH;
          OP_ADDI, OP_ADDIU, OP_SLTI,
          OP_ANDI, OP_ORI, OP_XORI: next_state = IMMEX;
          OP_J:    next_state = JUMP;
          default: decode_illegal = 1'b1;
        endcase
      end
      MEMADR:  next_state = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   next_state = MEMWB;
      EXEC:    next_state = ALUWB;
      IMMEX:   next_state = IMMWB;
      default: next_state = FETCH;
    endcase
  end

  // State register and fetch counter; every FETCH cycle outside reset
  // counts one instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FETCH;
      icount <= '0;
    end else begin
      state <= next_state;
      if (state == FETCH) icount <= icount + CNT_WIDTH'(1);
    end
  end

  // Moore output decode. Write enables and the illegal pulse are masked
  // while reset is high so an abandoned instruction cannot modify state.
  always_comb begin
    alufun   = 4'b0000;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    zext     = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    pcsrc    = 2'b00;
    pcen     = 1'b0;
    illegal  = 1'b0;
    case (state)
      FETCH:  begin alusrcb = 2'b01; alufun = 4'b0110; irwrite = 1'b1; pcen = 1'b1; end
      DECODE: begin alusrcb = 2'b11; alufun = 4'b0110; illegal = decode_illegal; end
      MEMADR: begin alusrca = 1'b1; alusrcb = 2'b10; alufun = 4'b0110; end
      MEMRD:  iord = 1'b1;
      MEMWB:  begin memtoreg = 1'b1; regwrite = 1'b1; end
      MEMWR:  begin iord = 1'b1; memwrite = 1'b1; end
      EXEC:   begin alusrca = 1'b1; alufun = rtype_alufun; end
      ALUWB:  begin regdst = 1'b1; regwrite = 1'b1; end
      BRANCH: begin
        alusrca = 1'b1;
        alufun  = 4'b1110;
        pcsrc   = 2'b01;
        pcen    = (opcode == OP_BNE) ? ~zero : zero;
      end
      IMMEX:  begin alusrca = 1'b1; alusrcb = 2'b10; alufun = imm_alufun; zext = imm_zext; end
      IMMWB:  begin regwrite = 1'b1; zext = imm_zext; end
      JUMP:   begin pcsrc = 2'b10; pcen = 1'b1; end
      default: alufun = 4'b0000;
    endcase
    if (reset) begin
      pcen     = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: table-driven bench for mc_control.
//
// Each table record is one clock cycle: the inputs to drive and the control
// word and instruction count expected during that cycle. The driver applies a
// record just after the rising edge and pushes its expectation to a queue; the
// checker pops and compares on the falling edge. A narrow counter width lets
// the run wrap icount.
module tb_mc_control;

  localparam int CW = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef struct packed {
    logic [3:0] alufun;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zext;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    logic          rst;
    logic [5:0]    op;
    logic [5:0]    fn;
    logic          z;
    ctrl_t         ctrl;
    logic [CW-1:0] ic;
  } vec_t;

  typedef struct packed {
    ctrl_t         ctrl;
    logic [CW-1:0] ic;
  } exp_t;

  localparam ctrl_t C_FETCH     = '{alufun:4'b0110, alusrcb:2'b01, irwrite:1'b1, pcen:1'b1, default:'0};
  localparam ctrl_t C_FETCH_RST = '{alufun:4'b0110, alusrcb:2'b01, default:'0};
  localparam ctrl_t C_DECODE    = '{alufun:4'b0110, alusrcb:2'b11, default:'0};
  localparam ctrl_t C_DEC_ILL   = '{alufun:4'b0110, alusrcb:2'b11, illegal:1'b1, default:'0};
  localparam ctrl_t C_MEMADR    = '{alufun:4'b0110, alusrca:1'b1, alusrcb:2'b10, default:'0};
  localparam ctrl_t C_MEMRD     = '{iord:1'b1, default:'0};
  localparam ctrl_t C_MEMWB     = '{memtoreg:1'b1, regwrite:1'b1, default:'0};
  localparam ctrl_t C_MEMWB_RST = '{memtoreg:1'b1, default:'0};
  localparam ctrl_t C_MEMWR     = '{iord:1'b1, memwrite:1'b1, default:'0};
  localparam ctrl_t C_MEMWR_RST = '{iord:1'b1, default:'0};
  localparam ctrl_t C_ALUWB     = '{regdst:1'b1, regwrite:1'b1, default:'0};
  localparam ctrl_t C_JUMP      = '{pcsrc:2'b10, pcen:1'b1, default:'0};
  localparam ctrl_t C_JUMP_RST  = '{pcsrc:2'b10, default:'0};

  logic          clk;
  logic          reset;
  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic          zero;
  logic [3:0]    alufun;
  logic          alusrca;
  logic [1:0]    alusrcb;
  logic          zext;
  logic          iord;
  logic          memwrite;
  logic          irwrite;
  logic          regwrite;
  logic          regdst;
  logic          memtoreg;
  logic [1:0]    pcsrc;
  logic          pcen;
  logic          illegal;
  logic [CW-1:0] icount;

  int checks;
  int errors;

  vec_t          vecs[$];
  exp_t          exp_q[$];
  logic [CW-1:0] exp_ic;

  mc_control #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .alufun(alufun), .alusrca(alusrca), .alusrcb(alusrcb), .zext(zext),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .pcsrc(pcsrc), .pcen(pcen),
    .illegal(illegal), .icount(icount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctrl_t c_exec(input logic [3:0] af);
    ctrl_t c;
    c = '0;
    c.alusrca = 1'b1;
    c.alufun  = af;
    return c;
  endfunction

  function automatic ctrl_t c_branch(input logic pe);
    ctrl_t c;
    c = '0;
    c.alusrca = 1'b1;
    c.alufun  = 4'b1110;
    c.pcsrc   = 2'b01;
    c.pcen    = pe;
    return c;
  endfunction

  function automatic ctrl_t c_immex(input logic [3:0] af, input logic zx);
    ctrl_t c;
    c = '0;
    c.alusrca = 1'b1;
    c.alusrcb = 2'b10;
    c.alufun  = af;
    c.zext    = zx;
    return c;
  endfunction

  function automatic ctrl_t c_immwb(input logic zx);
    ctrl_t c;
    c = '0;
    c.regwrite = 1'b1;
    c.zext     = zx;
    return c;
  endfunction

  // Table building helpers; exp_ic tracks the expected fetch count.
  task automatic add_vec(input logic r, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input ctrl_t c);
    vecs.push_back('{rst:r, op:op, fn:fn, z:z, ctrl:c, ic:exp_ic});
  endtask

  task automatic add_fetch(input logic [5:0] op, input logic [5:0] fn, input logic z);
    add_vec(1'b0, op, fn, z, C_FETCH);
    exp_ic = exp_ic + 1'b1;
  endtask

  // A reset cycle still shows the interrupted state but clears the count.
  task automatic add_reset(input logic [5:0] op, input ctrl_t c);
    add_vec(1'b1, op, 6'b0, 1'b0, c);
    exp_ic = '0;
  endtask

  task automatic add_lw();
    add_fetch(OP_LW, 6'h15, 1'b1);
    add_vec(1'b0, OP_LW, 6'h15, 1'b1, C_DECODE);
    add_vec(1'b0, OP_LW, 6'h15, 1'b0, C_MEMADR);
    add_vec(1'b0, OP_LW, 6'h15, 1'b1, C_MEMRD);
    add_vec(1'b0, OP_LW, 6'h15, 1'b0, C_MEMWB);
  endtask

  task automatic add_sw();
    add_fetch(OP_SW, 6'h2a, 1'b0);
    add_vec(1'b0, OP_SW, 6'h2a, 1'b0, C_DECODE);
    add_vec(1'b0, OP_SW, 6'h2a, 1'b1, C_MEMADR);
    add_vec(1'b0, OP_SW, 6'h2a, 1'b0, C_MEMWR);
  endtask

  task automatic add_rtype(input logic [5:0] fn, input logic [3:0] af);
    add_fetch(OP_RTYPE, fn, 1'b0);
    add_vec(1'b0, OP_RTYPE, fn, 1'b0, C_DECODE);
    add_vec(1'b0, OP_RTYPE, fn, 1'b1, c_exec(af));
    add_vec(1'b0, OP_RTYPE, fn, 1'b0, C_ALUWB);
  endtask

  task automatic add_branch(input logic [5:0] op, input logic z, input logic pe);
    add_fetch(op, 6'h00, z);
    add_vec(1'b0, op, 6'h00, z, C_DECODE);
    add_vec(1'b0, op, 6'h00, z, c_branch(pe));
  endtask

  task automatic add_imm(input logic [5:0] op, input logic [3:0] af, input logic zx);
    add_fetch(op, 6'h24, 1'b0);
    add_vec(1'b0, op, 6'h24, 1'b0, C_DECODE);
    add_vec(1'b0, op, 6'h24, 1'b0, c_immex(af, zx));
    add_vec(1'b0, op, 6'h24, 1'b1, c_immwb(zx));
  endtask

  task automatic add_jump();
    add_fetch(OP_J, 6'h0, 1'b0);
    add_vec(1'b0, OP_J, 6'h0, 1'b0, C_DECODE);
    add_vec(1'b0, OP_J, 6'h0, 1'b0, C_JUMP);
  endtask

  task automatic add_illegal(input logic [5:0] op, input logic [5:0] fn);
    add_fetch(op, fn, 1'b0);
    add_vec(1'b0, op, fn, 1'b0, C_DEC_ILL);
  endtask

  task automatic check_output(input string name, input int idx,
                              input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    reset  = v.rst;
    opcode = v.op;
    funct  = v.fn;
    zero   = v.z;
    exp_q.push_back('{ctrl:v.ctrl, ic:v.ic});
  endtask

  // Checker: compare the oldest outstanding expectation away from the edge.
  int cyc = 0;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t  e;
      ctrl_t act;
      e   = exp_q.pop_front();
      act = '{alufun:alufun, alusrca:alusrca, alusrcb:alusrcb, zext:zext, iord:iord,
              memwrite:memwrite, irwrite:irwrite, regwrite:regwrite, regdst:regdst,
              memtoreg:memtoreg, pcsrc:pcsrc, pcen:pcen, illegal:illegal};
      check_output("ctrl", cyc, 32'(act), 32'(e.ctrl));
      check_output("icount", cyc, 32'(icount), 32'(e.ic));
      cyc++;
    end
  end

  logic [5:0] fn_tab [9] = '{6'b101010, 6'b100011, 6'b100000, 6'b100001, 6'b100010,
                             6'b100100, 6'b100101, 6'b100110, 6'b100111};
  logic [3:0] af_tab [9] = '{4'b1111, 4'b1110, 4'b0110, 4'b0110, 4'b1110,
                             4'b0000, 4'b0001, 4'b0010, 4'b0011};

  initial begin
    checks = 0;
    errors = 0;
    exp_ic = '0;
    reset  = 1'b1;
    opcode = 6'b0;
    funct  = 6'b0;
    zero   = 1'b0;

    // Reset state: FETCH with all write enables masked, count held at 0.
    add_reset(OP_RTYPE, C_FETCH_RST);
    add_reset(OP_RTYPE, C_FETCH_RST);

    add_lw();
    add_sw();
    for (int i = 0; i < 9; i++) add_rtype(fn_tab[i], af_tab[i]);
    add_branch(OP_BEQ, 1'b1, 1'b1);
    add_branch(OP_BEQ, 1'b0, 1'b0);
    add_branch(OP_BNE, 1'b1, 1'b0);
    add_branch(OP_BNE, 1'b0, 1'b1);
    add_imm(OP_ORI,   4'b0001, 1'b1);
    add_imm(OP_SLTI,  4'b1111, 1'b0);
    add_imm(OP_ADDI,  4'b0110, 1'b0);
    add_imm(OP_ADDIU, 4'b0110, 1'b0);
    add_imm(OP_ANDI,  4'b0000, 1'b1);
    add_imm(OP_XORI,  4'b0010, 1'b1);
    add_jump();
    add_illegal(6'b111111, 6'b100000);
    add_illegal(OP_RTYPE,  6'b000000);
    add_illegal(6'b100000, 6'b000000);
    add_illegal(OP_RTYPE,  6'b001000);
    add_lw();

    // Reset held three cycles starting in EXEC, then a clean lw.
    add_fetch(OP_RTYPE, 6'b100000, 1'b0);
    add_vec(1'b0, OP_RTYPE, 6'b100000, 1'b0, C_DECODE);
    add_reset(OP_RTYPE, c_exec(4'b0110));
    add_reset(OP_RTYPE, C_FETCH_RST);
    add_reset(OP_RTYPE, C_FETCH_RST);
    add_lw();

    // Reset arriving in MEMWR must suppress memwrite.
    add_fetch(OP_SW, 6'h0, 1'b0);
    add_vec(1'b0, OP_SW, 6'h0, 1'b0, C_DECODE);
    add_vec(1'b0, OP_SW, 6'h0, 1'b0, C_MEMADR);
    add_reset(OP_SW, C_MEMWR_RST);
    add_jump();

    // Reset arriving in MEMWB must suppress regwrite.
    add_fetch(OP_LW, 6'h0, 1'b0);
    add_vec(1'b0, OP_LW, 6'h0, 1'b0, C_DECODE);
    add_vec(1'b0, OP_LW, 6'h0, 1'b0, C_MEMADR);
    add_vec(1'b0, OP_LW, 6'h0, 1'b0, C_MEMRD);
    add_reset(OP_LW, C_MEMWB_RST);
    add_imm(OP_ORI, 4'b0001, 1'b1);

    // Reset during an illegal DECODE masks the pulse; reset in JUMP masks pcen.
    add_fetch(6'b111111, 6'h0, 1'b0);
    add_reset(6'b111111, C_DECODE);
    add_fetch(OP_J, 6'h0, 1'b0);
    add_vec(1'b0, OP_J, 6'h0, 1'b0, C_DECODE);
    add_reset(OP_J, C_JUMP_RST);
    add_branch(OP_BEQ, 1'b1, 1'b1);
    add_sw();

    @(posedge clk);
    foreach (vecs[i]) begin
      #1;
      apply_stimulus(vecs[i]);
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle MIPS control unit: the sequencing FSM that drives the 4-bit ALU function code, datapath mux selects and write enables of the multi-cycle datapath. It decodes the opcode/funct held in the instruction register, steps each instruction through its fetch, decode, execute, memory and writeback cycles, and computes the PC enable from the ALU `zero` flag. It also counts fetched instructions for performance monitoring.

## Interface
- `CNT_WIDTH`, 32, width of the fetched-instruction counter
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `opcode` in 6: IR[31:26]; stable from DECODE onward (IR written only in FETCH)
- `funct` in 6: IR[5:0]
- `zero` in 1: ALU result == 0
- `alufun` out 4: ALU function; bit3 inverts B and sets carry-in; [2:0] 000 and, 001 or, 010 xor, 011 nor, 110 add/sub, 111 slt
- `alusrca` out 1: 0 = PC, 1 = register A
- `alusrcb` out 2: 00 reg B, 01 constant 4, 10 sign/zero-extended imm, 11 sign-ext imm<<2
- `zext` out 1: immediate zero-extended instead of sign-extended
- `iord` out 1: memory address 0 = PC, 1 = ALUOut
- `memwrite`, `irwrite`, `regwrite` out 1 each: write enables
- `regdst` out 1: 0 = rt, 1 = rd; `memtoreg` out 1: 0 = ALUOut, 1 = MDR
- `pcsrc` out 2: 00 ALU result, 01 ALUOut, 10 jump target
- `pcen` out 1: PC write enable
- `illegal` out 1: one-cycle pulse, unsupported instruction
- `icount` out CNT_WIDTH: instructions fetched since reset

## Operation
- Moore FSM, state register only; all outputs decode from state (plus `opcode`/`zero` where noted). Unlisted outputs are 0 in a state.
- FETCH: alusrcb=01, alufun=0110, irwrite=1, pcen=1 -> DECODE.
- DECODE: alusrcb=11, alufun=0110 (branch target into ALUOut). Next: lw/sw (100011/101011) -> MEMADR; R-type (000000) with supported funct -> EXEC; beq/bne (000100/000101) -> BRANCH; addi 001000, addiu 001001, slti 001010, andi 001100, ori 001101, xori 001110 -> IMMEX; j (000010) -> JUMP; anything else -> FETCH with illegal=1 in DECODE.
- MEMADR: alusrca=1, alusrcb=10, alufun=0110 -> MEMRD if lw, MEMWR if sw.
- MEMRD: iord=1 -> MEMWB. MEMWB: memtoreg=1, regwrite=1 -> FETCH.
- MEMWR: iord=1, memwrite=1 -> FETCH.
- EXEC: alusrca=1, alusrcb=00, alufun from funct: 100000/100001 -> 0110; 100010/100011 -> 1110; 100100 -> 0000; 100101 -> 0001; 100110 -> 0010; 100111 -> 0011; 101010 -> 1111 -> ALUWB. Any other funct counts as illegal at DECODE.
- ALUWB: regdst=1, regwrite=1 -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, alufun=1110, pcsrc=01; pcen = zero (beq) or ~zero (bne) -> FETCH.
- IMMEX: alusrca=1, alusrcb=10; alufun addi/addiu 0110, slti 1111, andi 0000, ori 0001, xori 0010; zext=1 for andi/ori/xori -> IMMWB.
- IMMWB: regdst=0, memtoreg=0, regwrite=1; zext held as in IMMEX -> FETCH.
- JUMP: pcsrc=10, pcen=1 -> FETCH.
- `icount` increments by 1 at every FETCH cycle and wraps modulo 2^CNT_WIDTH.

## Timing
- Reset (sampled at the edge): state <= FETCH, icount <= 0. While reset is high, pcen, irwrite, regwrite and memwrite are forced 0, illegal is forced 0, and icount does not increment. A reset mid-instruction abandons it; first FETCH follows the cycle reset falls.
- Cycles per instruction, FETCH to FETCH: lw 5, sw 4, R-type 4, addi-class 4, beq/bne 3, j 3, illegal 2.
- `alufun` is valid in the same cycle as the state; the datapath registers the ALU result at the end of that cycle.
- `pcen` in BRANCH is combinational on `zero` from the same cycle.
- `illegal` is high exactly one cycle (DECODE) per illegal instruction.

## Test plan
- Reset held 3 cycles mid-EXEC, then released -> state FETCH, icount=0, no write enables while reset is high; first FETCH asserts irwrite=1, pcen=1, alufun=0110.
- lw (opcode 100011) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in the 5th cycle; icount +1.
- R-type funct 101010 -> alufun=1111 in EXEC; funct 100011 -> 1110; ALUWB has regdst=1, regwrite=1.
- beq with zero=1 -> pcen=1, pcsrc=01 in cycle 3; beq zero=0 -> pcen=0; bne inverted.
- ori (001101) -> IMMEX alufun=0001, zext=1; IMMWB regwrite=1, regdst=0; slti -> alufun=1111, zext=0.
- opcode 111111, then R-type funct 000000 -> illegal pulses 1 cycle in DECODE, back to FETCH after 2 cycles each; icount incremented twice.
